uart_rx_param: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8-bit even-parity receiver.

---
 rtl/uart_rx_param.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with runtime parity mode, stop-bit and break checks,
// per-frame error qualifiers and a valid/ready output holding register.
module uart_rx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic [1:0]            parity_mode,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun,
    input  logic                  ovr_clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    line;
    logic                    line_prev;
    logic [1:0]              mode_q;
    logic                    par_en;
    logic                    par_odd;
    logic [CW-1:0]           clk_cnt;
    logic [BW-1:0]           bit_cnt;
    logic                    stop_cnt;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_err_q;
    logic                    frm_err_q;
    logic                    any_high_q;
    logic                    done_q;
    logic                    bit_tick;

    assign line     = sync_q[SYNC_STAGES-1];
    assign par_en   = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign par_odd  = (mode_q == 2'b10);
    assign bit_tick = (clk_cnt == FULL_M1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            sync_q     <= '1;
            line_prev  <= 1'b1;
            mode_q     <= '0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            any_high_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], serial_in};
            line_prev <= line;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_prev && !line) begin
                        state      <= START;
                        clk_cnt    <= '0;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        mode_q     <= parity_mode;
                        par_err_q  <= 1'b0;
                        frm_err_q  <= 1'b0;
                        any_high_q <= 1'b0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        state   <= line ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        clk_cnt    <= '0;
                        shift_q    <= {line, shift_q[DATA_WIDTH-1:1]};
                        any_high_q <= any_high_q | line;
                        if (bit_cnt == LAST_BIT) begin
                            state <= par_en ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        clk_cnt    <= '0;
                        par_err_q  <= ((^shift_q) ^ line) != par_odd;
                        any_high_q <= any_high_q | line;
                        state      <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        clk_cnt    <= '0;
                        any_high_q <= any_high_q | line;
                        if (!line) begin
                            frm_err_q <= 1'b1;
                        end
                        // Return to IDLE at the stop-bit centre so the next start edge is caught.
                        if (stop_cnt == LAST_STP) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_q;
                    parity_err <= par_err_q;
                    frame_err  <= frm_err_q;
                    break_det  <= !any_high_q;
                    rx_valid   <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (done_q && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one 1-stop-bit instance and one 2-stop-bit instance.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sl = 1'b1;
    logic       sl2 = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       rx_ready = 1'b1;
    logic       ovr_clr = 1'b0;

    logic [7:0] rx_data, rx_data2;
    logic       rx_valid, parity_err, frame_err, break_det, overrun;
    logic       rx_valid2, parity_err2, frame_err2, break_det2, overrun2;

    int vectors = 0;
    int miscompares = 0;

    int         vcnt = 0, vcnt2 = 0;
    logic [7:0] cap_data = '0, cap_data2 = '0;
    logic       cap_pe = 1'b0, cap_fe = 1'b0, cap_bd = 1'b0;
    logic       cap_fe2 = 1'b0, cap_bd2 = 1'b0;

    uart_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .SYNC_STAGES(3)) dut (
        .clk(clk), .reset(reset), .serial_in(sl), .parity_mode(parity_mode),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    uart_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .SYNC_STAGES(3)) dut2 (
        .clk(clk), .reset(reset), .serial_in(sl2), .parity_mode(parity_mode),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready),
        .parity_err(parity_err2), .frame_err(frame_err2), .break_det(break_det2),
        .overrun(overrun2), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt     <= vcnt + 1;
            cap_data <= rx_data;
            cap_pe   <= parity_err;
            cap_fe   <= frame_err;
            cap_bd   <= break_det;
        end
        if (rx_valid2) begin
            vcnt2     <= vcnt2 + 1;
            cap_data2 <= rx_data2;
            cap_fe2   <= frame_err2;
            cap_bd2   <= break_det2;
        end
    end

    task automatic drive(input bit which, input logic b);
        if (which) sl2 = b; else sl = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] d, input int has_par,
                              input logic par, input logic [1:0] stops, input int nstop);
        drive(which, 1'b0);
        for (int i = 0; i < 8; i++) drive(which, d[i]);
        if (has_par != 0) drive(which, par);
        for (int i = 0; i < nstop; i++) drive(which, stops[i]);
        for (int i = 0; i < 3; i++) drive(which, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", rx_data); end
        vectors++; if ({parity_err, frame_err, break_det, overrun} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {parity_err, frame_err, break_det, overrun}); end
        vectors++; if (rx_valid2 !== 1'b0) begin miscompares++; $display("FAIL reset_valid2 got %b exp 0", rx_valid2); end
        reset = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_8n1();
        int c0;
        parity_mode = 2'b00;
        c0 = vcnt;
        send_frame(1'b0, 8'h5A, 0, 1'b0, 2'b11, 1);
        vectors++; if (vcnt - c0 !== 1) begin miscompares++; $display("FAIL 8n1_valid_cycles got %0d exp 1", vcnt - c0); end
        vectors++; if (cap_data !== 8'h5A) begin miscompares++; $display("FAIL 8n1_data got %h exp 5a", cap_data); end
        vectors++; if ({cap_pe, cap_fe, cap_bd} !== 3'b000) begin miscompares++; $display("FAIL 8n1_flags got %b exp 000", {cap_pe, cap_fe, cap_bd}); end
    endtask

    task automatic test_parity();
        int c0;
        parity_mode = 2'b01;
        c0 = vcnt;
        send_frame(1'b0, 8'hA5, 1, 1'b0, 2'b11, 1);
        vectors++; if (vcnt - c0 !== 1) begin miscompares++; $display("FAIL even_valid_cycles got %0d exp 1", vcnt - c0); end
        vectors++; if (cap_data !== 8'hA5) begin miscompares++; $display("FAIL even_data got %h exp a5", cap_data); end
        vectors++; if (cap_pe !== 1'b0) begin miscompares++; $display("FAIL even_parity_err got %b exp 0", cap_pe); end
        parity_mode = 2'b10;
        c0 = vcnt;
        fork
            send_frame(1'b0, 8'hA5, 1, 1'b0, 2'b11, 1);
            begin
                repeat (3 * CPB) @(negedge clk);
                parity_mode = 2'b00;
            end
        join
        vectors++; if (vcnt - c0 !== 1) begin miscompares++; $display("FAIL odd_valid_cycles got %0d exp 1", vcnt - c0); end
        vectors++; if (cap_pe !== 1'b1) begin miscompares++; $display("FAIL odd_parity_err got %b exp 1", cap_pe); end
        vectors++; if (cap_fe !== 1'b0) begin miscompares++; $display("FAIL odd_frame_err got %b exp 0", cap_fe); end
        parity_mode = 2'b00;
    endtask

    task automatic test_glitch();
        int c0;
        c0 = vcnt;
        sl = 1'b0;
        repeat (5) @(negedge clk);
        sl = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        vectors++; if (vcnt - c0 !== 0) begin miscompares++; $display("FAIL glitch_no_valid got %0d exp 0", vcnt - c0); end
        send_frame(1'b0, 8'h33, 0, 1'b0, 2'b11, 1);
        vectors++; if (vcnt - c0 !== 1) begin miscompares++; $display("FAIL glitch_next_cycles got %0d exp 1", vcnt - c0); end
        vectors++; if (cap_data !== 8'h33) begin miscompares++; $display("FAIL glitch_next_data got %h exp 33", cap_data); end
        vectors++; if ({cap_pe, cap_fe, cap_bd} !== 3'b000) begin miscompares++; $display("FAIL glitch_next_flags got %b exp 000", {cap_pe, cap_fe, cap_bd}); end
    endtask

    task automatic test_two_stop();
        int c0;
        c0 = vcnt2;
        send_frame(1'b1, 8'hC3, 0, 1'b0, 2'b01, 2);
        vectors++; if (vcnt2 - c0 !== 1) begin miscompares++; $display("FAIL stop2_valid_cycles got %0d exp 1", vcnt2 - c0); end
        vectors++; if (cap_data2 !== 8'hC3) begin miscompares++; $display("FAIL stop2_data got %h exp c3", cap_data2); end
        vectors++; if ({cap_fe2, cap_bd2} !== 2'b10) begin miscompares++; $display("FAIL stop2_fe_bd got %b exp 10", {cap_fe2, cap_bd2}); end
        c0 = vcnt2;
        send_frame(1'b1, 8'h3C, 0, 1'b0, 2'b11, 2);
        vectors++; if ({vcnt2 - c0 == 1, cap_data2, cap_fe2} !== {1'b1, 8'h3C, 1'b0}) begin miscompares++; $display("FAIL stop2_clean got %0d/%h/%b exp 1/3c/0", vcnt2 - c0, cap_data2, cap_fe2); end
    endtask

    task automatic test_break();
        int c0;
        c0 = vcnt;
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        vectors++; if (vcnt - c0 !== 1) begin miscompares++; $display("FAIL break_valid_cycles got %0d exp 1", vcnt - c0); end
        vectors++; if (cap_data !== 8'h00) begin miscompares++; $display("FAIL break_data got %h exp 00", cap_data); end
        vectors++; if ({cap_fe, cap_bd} !== 2'b11) begin miscompares++; $display("FAIL break_fe_bd got %b exp 11", {cap_fe, cap_bd}); end
    endtask

    task automatic test_overrun();
        int c0;
        rx_ready = 1'b0;
        send_frame(1'b0, 8'h11, 0, 1'b0, 2'b11, 1);
        vectors++; if ({rx_valid, rx_data, overrun} !== {1'b1, 8'h11, 1'b0}) begin miscompares++; $display("FAIL ovr_first got %b/%h/%b exp 1/11/0", rx_valid, rx_data, overrun); end
        send_frame(1'b0, 8'h22, 0, 1'b0, 2'b11, 1);
        vectors++; if (rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_held_data got %h exp 11", rx_data); end
        vectors++; if ({rx_valid, overrun} !== 2'b11) begin miscompares++; $display("FAIL ovr_set got %b exp 11", {rx_valid, overrun}); end
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        @(negedge clk);
        vectors++; if ({rx_valid, rx_data, overrun} !== {1'b1, 8'h11, 1'b0}) begin miscompares++; $display("FAIL ovr_clr got %b/%h/%b exp 1/11/0", rx_valid, rx_data, overrun); end
        fork
            send_frame(1'b0, 8'hFF, 0, 1'b0, 2'b11, 1);
            begin
                repeat (3 * CPB) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                vectors++; if ({rx_valid, rx_data, parity_err, frame_err, break_det, overrun} !== 13'h0) begin miscompares++; $display("FAIL midreset_outputs got %b/%h/%b exp 0/00/0000", rx_valid, rx_data, {parity_err, frame_err, break_det, overrun}); end
            end
        join
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_discard got %b exp 0", rx_valid); end
        rx_ready = 1'b1;
        c0 = vcnt;
        send_frame(1'b0, 8'h96, 0, 1'b0, 2'b11, 1);
        vectors++; if (vcnt - c0 !== 1) begin miscompares++; $display("FAIL after_reset_cycles got %0d exp 1", vcnt - c0); end
        vectors++; if ({cap_data, cap_fe, overrun} !== {8'h96, 1'b0, 1'b0}) begin miscompares++; $display("FAIL after_reset_word got %h/%b/%b exp 96/0/0", cap_data, cap_fe, overrun); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_two_stop();
        test_break();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
